// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and FSM encoding for the UART transmitter arbiter.
package uart_arb_pkg;

  localparam int DEF_N_REQ        = 4;
  localparam int DEF_BUSY_TIMEOUT = 16;
  localparam int BYTE_W           = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle; master is the arbiter side.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
);

  logic [N_REQ-1:0]        req_valid;
  logic [BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic [BYTE_W-1:0]       tx_data;
  logic                    tx_data_valid;
  logic                    tx_busy;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_data_valid
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_data_valid
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after ptr, with wrap.
module rr_picker #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] idx,
  output logic           found
);

  int pos;

  // Scan farthest offset first so the nearest request after ptr wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = N; i >= 1; i--) begin
      pos = (int'(ptr) + i) % N;
      if (req[IDW'(pos)]) begin
        idx   = IDW'(pos);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ producers.
// Define UART_ARB_LOCK_EN to hold the grant until a req_last byte is accepted.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ        = DEF_N_REQ,
  parameter  int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  localparam int IDW          = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_arbiter_if.master   bus,
  output logic [IDW-1:0]      grant_id,
  output logic                arb_busy,
  output logic                err_timeout
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              err_q, err_d;
  logic [IDW-1:0]    grant_q, grant_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0]  req_mask;
  logic [IDW-1:0]    win_idx;
  logic              win_found;
  logic [BYTE_W-1:0] win_byte;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;

  // A locked message only lets its own requester compete.
  always_comb begin
    req_mask = bus.req_valid;
    if (lock_q) begin
      req_mask          = '0;
      req_mask[grant_q] = bus.req_valid[grant_q];
    end
  end
`else
  logic unused_last;
  assign unused_last = ^bus.req_last;
  assign req_mask    = bus.req_valid;
`endif

  rr_picker #(.N(N_REQ)) u_picker (
    .req   (req_mask),
    .ptr   (ptr_q),
    .idx   (win_idx),
    .found (win_found)
  );

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == win_idx) win_byte = bus.req_data[i*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && win_found) bus.req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
`ifdef UART_ARB_LOCK_EN
    lock_d     = lock_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          tx_data_d  = win_byte;
          grant_d    = win_idx;
          ptr_d      = win_idx;
          tx_valid_d = 1'b1;
          state_d    = LAUNCH;
`ifdef UART_ARB_LOCK_EN
          lock_d     = !bus.req_last[win_idx];
`endif
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never started: drop the byte rather than retry.
          err_d   = 1'b1;
          state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      grant_q    <= '0;
      ptr_q      <= IDW'(N_REQ - 1);
      cnt_q      <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
`ifdef UART_ARB_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign bus.tx_data       = tx_data_q;
  assign bus.tx_data_valid = tx_valid_q;
  assign grant_id          = grant_q;
  assign err_timeout       = err_q;
  assign arb_busy          = (state_q != IDLE);

endmodule
